// File: rtl/access_keypad_entry.sv
// Keypad front-end: three decimal keys -> 12-bit binary code, valid/ack handshake, reject lockout.
// Latency: all outputs registered; a key strobe at edge n is visible right after edge n.
// Backpressure: code held in PRESENT until accept/reject; keys are dropped while presenting or locked.
module access_keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        accept,
  input  logic        reject,
  output logic [11:0] access_code,
  output logic        code_valid,
  output logic [1:0]  digit_count,
  output logic        locked,
  output logic        entry_error
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [3:0]       ATTEMPT_LIMIT = 4'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_PRESENT = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [11:0]      accum;
  logic [11:0]      accum_nxt;
  logic [11:0]      access_code_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [3:0]       attempts;
  logic [3:0]       attempts_nxt;
  logic [1:0]       digit_count_nxt;
  logic             code_valid_nxt;
  logic             locked_nxt;
  logic             entry_error_nxt;

  logic             key_is_digit;
  logic             key_is_clear;
  logic             key_is_enter;
  logic             key_is_bad;
  logic             entry_full;
  logic             timed_out;
  logic             lock_done;
  logic             last_attempt;

  always_comb begin
    key_is_digit = key_valid && (key_digit <= 4'd9);
    key_is_clear = key_valid && (key_digit == 4'd10);
    key_is_enter = key_valid && (key_digit == 4'd11);
    key_is_bad   = key_valid && (key_digit >= 4'd12);
    entry_full   = (digit_count == 2'd3);
    // One timer serves both the inter-key timeout (ENTRY) and the lockout (LOCKOUT).
    timed_out    = !key_valid && (timer == TIMEOUT_LAST);
    lock_done    = (timer == LOCKOUT_LAST);
    last_attempt = ((attempts + 4'd1) == ATTEMPT_LIMIT);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      accum       <= '0;
      timer       <= '0;
      attempts    <= '0;
      access_code <= '0;
      code_valid  <= 1'b0;
      digit_count <= '0;
      locked      <= 1'b0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      accum       <= accum_nxt;
      timer       <= timer_nxt;
      attempts    <= attempts_nxt;
      access_code <= access_code_nxt;
      code_valid  <= code_valid_nxt;
      digit_count <= digit_count_nxt;
      locked      <= locked_nxt;
      entry_error <= entry_error_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (key_is_digit) state_nxt = S_ENTRY;
      end
      S_ENTRY: begin
        if (key_is_clear)      state_nxt = S_IDLE;
        else if (key_is_enter) state_nxt = entry_full ? S_PRESENT : S_IDLE;
        else if (timed_out)    state_nxt = S_IDLE;
      end
      S_PRESENT: begin
        if (reject)      state_nxt = last_attempt ? S_LOCKOUT : S_IDLE;
        else if (accept) state_nxt = S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for datapath and registered outputs
  always_comb begin
    accum_nxt       = accum;
    timer_nxt       = '0;
    attempts_nxt    = attempts;
    access_code_nxt = access_code;
    code_valid_nxt  = code_valid;
    digit_count_nxt = digit_count;
    locked_nxt      = locked;
    entry_error_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_is_digit) begin
          accum_nxt       = {8'd0, key_digit};
          digit_count_nxt = 2'd1;
        end
      end
      S_ENTRY: begin
        timer_nxt = key_valid ? '0 : timer + CNT_ONE;
        if (key_is_digit) begin
          if (entry_full) begin
            entry_error_nxt = 1'b1;
          end else begin
            accum_nxt       = accum * 12'd10 + {8'd0, key_digit};
            digit_count_nxt = digit_count + 2'd1;
          end
        end else if (key_is_clear) begin
          accum_nxt       = '0;
          digit_count_nxt = '0;
        end else if (key_is_enter) begin
          accum_nxt       = '0;
          digit_count_nxt = '0;
          if (entry_full) begin
            access_code_nxt = accum;
            code_valid_nxt  = 1'b1;
          end else begin
            entry_error_nxt = 1'b1;
          end
        end else if (key_is_bad) begin
          entry_error_nxt = 1'b1;
        end else if (timed_out) begin
          accum_nxt       = '0;
          digit_count_nxt = '0;
          entry_error_nxt = 1'b1;
          timer_nxt       = '0;
        end
      end
      S_PRESENT: begin
        // Reject takes priority when both acknowledges arrive together.
        if (reject) begin
          code_valid_nxt = 1'b0;
          if (last_attempt) begin
            attempts_nxt = '0;
            locked_nxt   = 1'b1;
          end else begin
            attempts_nxt = attempts + 4'd1;
          end
        end else if (accept) begin
          code_valid_nxt = 1'b0;
          attempts_nxt   = '0;
        end
      end
      S_LOCKOUT: begin
        if (lock_done) locked_nxt = 1'b0;
        else           timer_nxt  = timer + CNT_ONE;
      end
      default: begin
        accum_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_access_keypad_entry.sv
// Bench for access_keypad_entry: directed scenarios plus randomized traffic against a digit-queue model.
module tb_access_keypad_entry;

  localparam int T_TO  = 20;
  localparam int T_MAX = 3;
  localparam int T_LO  = 50;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        accept;
  logic        reject;
  logic [11:0] access_code;
  logic        code_valid;
  logic [1:0]  digit_count;
  logic        locked;
  logic        entry_error;

  int n_cmp;
  int n_bad;

  access_keypad_entry #(
    .TIMEOUT_CYCLES(T_TO),
    .MAX_ATTEMPTS  (T_MAX),
    .LOCKOUT_CYCLES(T_LO),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .accept     (accept),
    .reject     (reject),
    .access_code(access_code),
    .code_valid (code_valid),
    .digit_count(digit_count),
    .locked     (locked),
    .entry_error(entry_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] dut_vec;
  assign dut_vec = {access_code, code_valid, digit_count, locked, entry_error};

  // Reference model: digits kept in a queue, lockout as a countdown of remaining cycles.
  int m_digits[$];
  int m_code;
  bit m_valid;
  int m_lock_left;
  int m_idle;
  int m_attempts;
  bit m_err;

  function automatic logic [16:0] exp_vec();
    return {12'(m_code), m_valid, 2'(m_digits.size()), (m_lock_left > 0), m_err};
  endfunction

  task automatic model_step(input logic kv, input logic [3:0] kd, input logic acc,
                            input logic rej, input logic r);
    m_err = 1'b0;
    if (r) begin
      m_digits.delete();
      m_code = 0; m_valid = 1'b0; m_lock_left = 0; m_idle = 0; m_attempts = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (m_valid) begin
      if (rej) begin
        m_valid = 1'b0;
        m_attempts++;
        if (m_attempts == T_MAX) begin
          m_attempts  = 0;
          m_lock_left = T_LO;
        end
      end else if (acc) begin
        m_valid    = 1'b0;
        m_attempts = 0;
      end
    end else if (kv) begin
      m_idle = 0;
      if (kd <= 9) begin
        if (m_digits.size() < 3) m_digits.push_back(int'(kd));
        else m_err = 1'b1;
      end else if (m_digits.size() > 0) begin
        if (kd == 11) begin
          if (m_digits.size() == 3) begin
            m_code  = m_digits[0] * 100 + m_digits[1] * 10 + m_digits[2];
            m_valid = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_digits.delete();
        end else if (kd == 10) begin
          m_digits.delete();
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle == T_TO) begin
        m_digits.delete();
        m_err  = 1'b1;
        m_idle = 0;
      end
    end
  endtask

  task automatic step(input logic kv, input logic [3:0] kd, input logic acc,
                      input logic rej, input logic r);
    rst = r; key_valid = kv; key_digit = kd; accept = acc; reject = rej;
    @(posedge clk);
    model_step(kv, kd, acc, rej, r);
    #1;
    rst = 1'b0; key_valid = 1'b0; accept = 1'b0; reject = 1'b0;
  endtask

  task automatic press(input int d);
    step(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack(input logic acc, input logic rej);
    step(1'b0, 4'd0, acc, rej, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec !== 17'd0) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", dut_vec, 17'd0);
    end
  endtask

  task automatic test_basic_code();
    int keys[4] = '{7, 3, 1, 11};
    foreach (keys[i]) begin
      press(keys[i]);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL basic_key%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (access_code !== 12'h2DB || code_valid !== 1'b1 || digit_count !== 2'd0) begin
      n_bad++; $display("FAIL basic_present: code %h valid %b cnt %0d want 2db 1 0",
                        access_code, code_valid, digit_count);
    end
    for (int i = 0; i < 5; i++) begin
      press(i + 2);
      n_cmp++;
      if (access_code !== 12'd731 || code_valid !== 1'b1) begin
        n_bad++; $display("FAIL basic_hold%0d: code %0d valid %b want 731 1", i, access_code, code_valid);
      end
    end
    ack(1'b1, 1'b0);
    n_cmp++;
    if (code_valid !== 1'b0 || access_code !== 12'd731) begin
      n_bad++; $display("FAIL basic_accept: valid %b code %0d want 0 731", code_valid, access_code);
    end
  endtask

  task automatic test_entry_errors();
    press(2); press(9); press(11);
    n_cmp++;
    if (entry_error !== 1'b1 || code_valid !== 1'b0 || digit_count !== 2'd0) begin
      n_bad++; $display("FAIL short_enter: err %b valid %b cnt %0d want 1 0 0",
                        entry_error, code_valid, digit_count);
    end
    idle();
    n_cmp++;
    if (entry_error !== 1'b0) begin
      n_bad++; $display("FAIL short_pulse_width: err %b want 0", entry_error);
    end
    press(1); press(2); press(3); press(4);
    n_cmp++;
    if (entry_error !== 1'b1 || digit_count !== 2'd3) begin
      n_bad++; $display("FAIL fourth_digit: err %b cnt %0d want 1 3", entry_error, digit_count);
    end
    press(13);
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL bad_code: got %h want %h", dut_vec, exp_vec());
    end
    press(11);
    n_cmp++;
    if (access_code !== 12'd123 || code_valid !== 1'b1) begin
      n_bad++; $display("FAIL overflow_enter: code %0d valid %b want 123 1", access_code, code_valid);
    end
    ack(1'b1, 1'b0);
  endtask

  task automatic test_clear();
    press(5);
    n_cmp++;
    if (digit_count !== 2'd1) begin
      n_bad++; $display("FAIL clear_pre: cnt %0d want 1", digit_count);
    end
    press(10);
    n_cmp++;
    if (digit_count !== 2'd0 || entry_error !== 1'b0) begin
      n_bad++; $display("FAIL clear: cnt %0d err %b want 0 0", digit_count, entry_error);
    end
    press(0); press(0); press(0); press(11);
    n_cmp++;
    if (access_code !== 12'd0 || code_valid !== 1'b1) begin
      n_bad++; $display("FAIL zero_code: code %0d valid %b want 0 1", access_code, code_valid);
    end
    ack(1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    press(4);
    for (int i = 1; i <= T_TO; i++) begin
      idle();
      n_cmp++;
      if (entry_error !== (i == T_TO) || digit_count !== ((i == T_TO) ? 2'd0 : 2'd1)) begin
        n_bad++; $display("FAIL timeout_idle%0d: err %b cnt %0d", i, entry_error, digit_count);
      end
    end
    idle();
    press(4);
    for (int i = 1; i < T_TO; i++) idle();
    press(5);
    n_cmp++;
    if (entry_error !== 1'b0 || digit_count !== 2'd2) begin
      n_bad++; $display("FAIL timer_restart: err %b cnt %0d want 0 2", entry_error, digit_count);
    end
    press(10);
  endtask

  task automatic test_lockout();
    int keys[4] = '{1, 9, 1, 11};
    for (int a = 1; a <= T_MAX; a++) begin
      foreach (keys[i]) press(keys[i]);
      n_cmp++;
      if (access_code !== 12'd191 || code_valid !== 1'b1) begin
        n_bad++; $display("FAIL lock_present%0d: code %0d valid %b", a, access_code, code_valid);
      end
      ack(1'b0, 1'b1);
      n_cmp++;
      if (locked !== (a == T_MAX) || code_valid !== 1'b0) begin
        n_bad++; $display("FAIL lock_reject%0d: locked %b valid %b", a, locked, code_valid);
      end
    end
    for (int i = 1; i <= T_LO; i++) begin
      step(1'b1, 4'(i % 12), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (locked !== (i < T_LO) || digit_count !== 2'd0 || dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL lock_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    press(1); press(2); press(3); press(11);
    n_cmp++;
    if (access_code !== 12'd123 || code_valid !== 1'b1 || locked !== 1'b0) begin
      n_bad++; $display("FAIL post_lock: code %0d valid %b locked %b", access_code, code_valid, locked);
    end
    ack(1'b1, 1'b0);
  endtask

  task automatic test_accept_reject_same();
    for (int a = 1; a <= T_MAX; a++) begin
      press(2); press(0); press(0); press(11);
      if (a == 1) ack(1'b1, 1'b1);
      else        ack(1'b0, 1'b1);
      n_cmp++;
      if (code_valid !== 1'b0 || locked !== (a == T_MAX) || access_code !== 12'd200) begin
        n_bad++; $display("FAIL both_ack%0d: valid %b locked %b code %0d", a, code_valid, locked, access_code);
      end
    end
    for (int i = 0; i < T_LO; i++) idle();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL both_ack_unlock: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_entry();
    press(4); press(5);
    n_cmp++;
    if (digit_count !== 2'd2) begin
      n_bad++; $display("FAIL mid_entry_pre: cnt %0d want 2", digit_count);
    end
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (dut_vec !== 17'd0) begin
      n_bad++; $display("FAIL mid_entry_reset: got %h want %h", dut_vec, 17'd0);
    end
  endtask

  task automatic test_random();
    int kv_pct;
    int x;
    logic kv;
    logic [3:0] kd;
    for (int blk = 0; blk < 15; blk++) begin
      x = $urandom_range(0, 2);
      kv_pct = (x == 0) ? 4 : ((x == 1) ? 30 : 70);
      for (int c = 0; c < 200; c++) begin
        x  = $urandom_range(0, 99);
        kd = (x < 75) ? 4'(x % 10) : 4'(10 + x % 6);
        kv = ($urandom_range(0, 99) < kv_pct);
        step(kv, kd, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 999) == 0));
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_bad++;
          if (n_bad < 20) $display("FAIL random_b%0d_c%0d: got %h want %h", blk, c, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; key_valid = 1'b0; key_digit = 4'd0; accept = 1'b0; reject = 1'b0;
    m_code = 0; m_valid = 1'b0; m_lock_left = 0; m_idle = 0; m_attempts = 0; m_err = 1'b0;
    #1;
    test_reset();
    test_basic_code();
    test_entry_errors();
    test_clear();
    test_timeout();
    test_lockout();
    test_accept_reject_same();
    test_reset_mid_entry();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
